// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing helpers for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int MAX_WIDTH = 32;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] min_val(input int w);
        return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division row, shift in a dividend bit and trial-subtract the divisor
module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {i_rem, i_bit};
    assign w_trial = w_shift - {1'b0, i_dvs};
    assign o_qbit  = ~w_trial[WIDTH];
    assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative signed/unsigned restoring divider, one quotient bit per clock
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz,
    output logic             ovf
);

    localparam int               CW  = cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] MIN = WIDTH'(min_val(WIDTH));

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dbz;
    logic             r_ovf;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_qbit;
    logic             w_accept;
    logic             w_dbz;
    logic             w_ovf;
    logic             w_last;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_dbz    = (b == '0);
    assign w_ovf    = is_signed && (a == MIN) && (b == '1);
    assign w_abs_a  = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (is_signed && b[WIDTH-1]) ? -b : b;
    assign w_last   = (r_cnt == '0);
    assign w_q_nx   = {r_dvd[WIDTH-2:0], w_qbit};

    assign q   = r_q;
    assign r   = r_r;
    assign dbz = r_dbz;
    assign ovf = r_ovf;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_nx),
        .o_qbit (w_qbit)
    );

    // Next-state selection and handshake outputs; flagged cases skip the iteration
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = (w_dbz || w_ovf) ? DONE : BUSY;
            end
            BUSY: if (w_last) w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Operand capture, per-cycle restoring step and final sign fix-up
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_dbz    <= w_dbz;
            r_ovf    <= w_ovf;
            r_rem    <= '0;
            r_dvd    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_cnt    <= CW'(WIDTH - 1);
            r_sign_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_sign_r <= is_signed && a[WIDTH-1];
            if (w_dbz || w_ovf) begin
                r_q <= w_dbz ? '1 : MIN;
                r_r <= w_dbz ? a : '0;
            end
        end else if (r_state == BUSY) begin
            r_rem <= w_rem_nx;
            r_dvd <= w_q_nx;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_q <= r_sign_q ? -w_q_nx : w_q_nx;
                r_r <= r_sign_r ? -w_rem_nx : w_rem_nx;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized scoreboard bench for seq_divider against an arithmetic reference
module tb_seq_divider;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           acc;
        int           lat;
        int           hold;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         is_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   issued = 0;
    int   seen = 0;
    exp_t exp_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
        exp_t   e;
        longint sa;
        longint sb;
        e = '{q: '0, r: '0, dbz: 1'b0, ovf: 1'b0, acc: 0, lat: 0, hold: 0};
        sa = ms ? longint'($signed(ma)) : longint'(ma);
        sb = ms ? longint'($signed(mb)) : longint'(mb);
        if (sb == 0) begin
            e.q   = '1;
            e.r   = ma;
            e.dbz = 1'b1;
        end else if (ms && sa == -(longint'(1) <<< (W - 1)) && sb == -1) begin
            e.q   = ma;
            e.ovf = 1'b1;
        end else begin
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
        end
        e.lat = (e.dbz || e.ovf) ? 1 : W + 1;
        return e;
    endfunction

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                         input int hold, input bit track);
        exp_t e;
        int   n;
        @(negedge clk);
        a = ta;
        b = tb_;
        is_signed = ts;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%0b expected=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (track) begin
            e = model(ta, tb_, ts);
            e.acc = cyc + 1;
            e.hold = hold;
            exp_q.push_back(e);
            issued++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        is_signed = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (seen != issued && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (seen != issued) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout seen=%0d expected=%0d", seen, issued);
        end
    endtask

    // Monitor: pops an expectation whenever a result is presented and checks it through backpressure
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result q=%0h r=%0h expected=none", q, r);
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    chk("q", q, e.q);
                    chk("r", r, e.r);
                    chk("dbz", dbz, e.dbz);
                    chk("ovf", ovf, e.ovf);
                    chk("latency", cyc - e.acc + 1, e.lat);
                    chk("in_ready_done", in_ready, 1'b0);
                    for (int i = 0; i < e.hold; i++) begin
                        @(negedge clk);
                        chk("hold_valid", out_valid, 1'b1);
                        chk("hold_in_ready", in_ready, 1'b0);
                        chk("hold_q", q, e.q);
                        chk("hold_r", r, e.r);
                        chk("hold_flags", {dbz, ovf}, {e.dbz, e.ovf});
                    end
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                    chk("valid_drop", out_valid, 1'b0);
                    seen++;
                end
            end
        end
    end

    // Stimulus: directed corner cases, random operations, then reset during iteration
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_q", q, '0);
        chk("rst_r", r, '0);
        chk("rst_flags", {dbz, ovf}, 2'b00);
        rst_n = 1'b1;
        do_op(8'd200, 8'd7, 1'b0, 0, 1'b1);
        do_op(8'h9C, 8'd7, 1'b1, 1, 1'b1);
        do_op(8'd100, 8'hF9, 1'b1, 0, 1'b1);
        do_op(8'd45, 8'd0, 1'b0, 0, 1'b1);
        do_op(8'd45, 8'd0, 1'b1, 0, 1'b1);
        do_op(8'd10, 8'd3, 1'b0, 0, 1'b1);
        do_op(8'h80, 8'hFF, 1'b1, 0, 1'b1);
        do_op(8'h80, 8'hFF, 1'b0, 0, 1'b1);
        do_op(8'd77, 8'hFB, 1'b1, 5, 1'b1);
        do_op(8'd13, 8'd4, 1'b0, 0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 8'h80; rb = 8'hFF; end
                2: rb = 8'd1;
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'b1);
        end
        drain();
        do_op(8'd200, 8'd3, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_q", q, '0);
        chk("midrst_r", r, '0);
        do_op(8'd255, 8'd16, 1'b0, 0, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
